// File: rtl/fpga_link_transmitter.sv
// fpga_link_transmitter: serialises a host word onto a single data line,
// one four-phase req/ack handshake per bit, with optional parity and timeout.
//
// Ports:
//   clk      - single clock, all state on the rising edge
//   reset    - asynchronous active-low reset
//   send     - host request level, launches one frame per rising level
//   data_in  - payload word, captured in LOAD only
//   ack_in   - remote acknowledge, asynchronous, synchronised internally
//   tx_bit   - current serial bit
//   tx_req   - bit-valid request to the remote board
//   busy     - low only while idle and re-armed
//   done     - one-cycle pulse when a frame completes
//   error    - one-cycle pulse when an acknowledge wait times out
module fpga_link_transmitter #(
    parameter int DATA_W      = 8,
    parameter int PARITY      = 0,
    parameter int MSB_FIRST   = 1,
    parameter int TIMEOUT     = 1023,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ack_in,
    output logic              tx_bit,
    output logic              tx_req,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int N    = DATA_W + ((PARITY != 0) ? 1 : 0);
    localparam int BC_W = $clog2(N + 1);
    localparam int WC_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [BC_W-1:0] LAST = BC_W'(N - 1);
    localparam logic [WC_W-1:0] TMAX = WC_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_REQ_HI,
        S_REQ_LO,
        S_NEXT,
        S_DONE,
        S_ERR,
        S_HOLD
    } state_t;

    state_t                 state;
    logic [N-1:0]           sreg;
    logic [N-1:0]           shifted;
    logic [N-1:0]           frame;
    logic [DATA_W-1:0]      ordered;
    logic                   par_bit;
    logic [BC_W-1:0]        bcnt;
    logic [WC_W-1:0]        wcnt;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic                   timed_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // The frame is held with the next bit to send in the top position,
    // so the payload is pre-ordered and parity lands in bit 0.
    always_comb begin
        ordered = data_in;
        if (MSB_FIRST == 0) begin
            for (int i = 0; i < DATA_W; i++) begin
                ordered[i] = data_in[DATA_W-1-i];
            end
        end
        par_bit = (^data_in) ^ (PARITY == 2);
        frame = '0;
        frame[N-1 -: DATA_W] = ordered;
        if (PARITY != 0) begin
            frame[0] = par_bit;
        end
    end

    assign shifted   = sreg << 1;
    assign timed_out = (TIMEOUT != 0) && (wcnt == TMAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_HOLD;
            sreg   <= '0;
            bcnt   <= '0;
            wcnt   <= '0;
            tx_bit <= 1'b0;
            tx_req <= 1'b0;
            busy   <= 1'b1;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (send) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    sreg   <= frame;
                    tx_bit <= frame[N-1];
                    bcnt   <= '0;
                    wcnt   <= '0;
                    state  <= S_REQ_HI;
                end
                S_REQ_HI: begin
                    // Only accept ack once our request is actually visible,
                    // so a stale high ack still yields a real req pulse.
                    if (tx_req && ack_s) begin
                        tx_req <= 1'b0;
                        wcnt   <= '0;
                        state  <= S_REQ_LO;
                    end else if (timed_out) begin
                        tx_req <= 1'b0;
                        error  <= 1'b1;
                        state  <= S_ERR;
                    end else begin
                        tx_req <= 1'b1;
                        wcnt   <= wcnt + 1'b1;
                    end
                end
                S_REQ_LO: begin
                    if (!ack_s) begin
                        if (bcnt == LAST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (timed_out) begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    sreg   <= shifted;
                    tx_bit <= shifted[N-1];
                    bcnt   <= bcnt + 1'b1;
                    wcnt   <= '0;
                    state  <= S_REQ_HI;
                end
                S_DONE: begin
                    state <= S_HOLD;
                end
                S_ERR: begin
                    state <= S_HOLD;
                end
                S_HOLD: begin
                    // Re-arm only after the host drops send.
                    if (!send) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_HOLD;
                end
            endcase
        end
    end

endmodule
